dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter.sv | 146 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that lets two masters share one single-port data memory.
// Each access spends one ISSUE cycle driving the memory and one RESP cycle returning the result.
module dmem_arbiter #(
   parameter int WORD        = 32,
   parameter int DMEM_OFFSET = 0,
   parameter int DMEM_DEPTH  = 1024,
   parameter int AW          = 10
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            m0_req,
   input  logic            m0_we,
   input  logic [WORD-1:0] m0_addr,
   input  logic [WORD-1:0] m0_wdata,
   output logic            m0_gnt,
   output logic            m0_rvalid,
   output logic [WORD-1:0] m0_rdata,
   output logic            m0_err,
   input  logic            m1_req,
   input  logic            m1_we,
   input  logic [WORD-1:0] m1_addr,
   input  logic [WORD-1:0] m1_wdata,
   output logic            m1_gnt,
   output logic            m1_rvalid,
   output logic [WORD-1:0] m1_rdata,
   output logic            m1_err,
   output logic            mem_we,
   output logic [AW-1:0]   mem_addr,
   output logic [WORD-1:0] mem_wdata,
   input  logic [WORD-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      RESP  = 2'd2
   } state_e;

   localparam logic [WORD-1:0] OffsetW = WORD'(DMEM_OFFSET);
   localparam logic [WORD-1:0] DepthW  = WORD'(DMEM_DEPTH);

   state_e            state_q, state_d;
   logic              owner_q;
   logic              lastGnt_q;
   logic              we_q;
   logic [WORD-1:0]   addr_q;
   logic [WORD-1:0]   wdata_q;
   logic [WORD-1:0]   rdata0_q;
   logic [WORD-1:0]   rdata1_q;

   logic              anyReq;
   logic              winner;
   logic              accept;
   logic [WORD-1:0]   wordAddr;
   logic [WORD-1:0]   relAddr;
   logic              fault;
   logic [WORD-1:0]   respData;

   assign anyReq   = m0_req | m1_req;
   // On a tie the master that did not win last time goes next.
   assign winner   = (m0_req && m1_req) ? ~lastGnt_q : m1_req;
   assign accept   = (state_q != ISSUE) && anyReq;

   assign wordAddr = addr_q >> 2;
   assign relAddr  = wordAddr - OffsetW;
   assign fault    = (addr_q[1:0] != 2'b00) || (wordAddr < OffsetW) || (relAddr >= DepthW);
   assign respData = (we_q || fault) ? '0 : mem_rdata;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = IDLE;
      case (state_q)
         IDLE, RESP: state_d = anyReq ? ISSUE : IDLE;
         ISSUE:      state_d = RESP;
         default:    state_d = IDLE;
      endcase
   end

   // Request capture on acceptance, read-data capture at the end of ISSUE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q   <= 1'b0;
         lastGnt_q <= 1'b1;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
      end else begin
         if (accept) begin
            owner_q   <= winner;
            lastGnt_q <= winner;
            we_q      <= winner ? m1_we    : m0_we;
            addr_q    <= winner ? m1_addr  : m0_addr;
            wdata_q   <= winner ? m1_wdata : m0_wdata;
         end
         if (state_q == ISSUE) begin
            if (owner_q) begin
               rdata1_q <= respData;
            end else begin
               rdata0_q <= respData;
            end
         end
      end
   end

   assign m0_rdata = rdata0_q;
   assign m1_rdata = rdata1_q;

   always_comb begin
      m0_gnt    = 1'b0;
      m1_gnt    = 1'b0;
      m0_rvalid = 1'b0;
      m1_rvalid = 1'b0;
      m0_err    = 1'b0;
      m1_err    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state_q)
         ISSUE: begin
            m0_gnt    = ~owner_q;
            m1_gnt    = owner_q;
            mem_we    = we_q & ~fault;
            mem_addr  = relAddr[AW-1:0];
            mem_wdata = wdata_q;
         end
         RESP: begin
            m0_rvalid = ~owner_q;
            m1_rvalid = owner_q;
            m0_err    = ~owner_q & fault;
            m1_err    = owner_q & fault;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a transaction-level model.
module tb_dmem_arbiter;

   localparam int OFFSET = 8;
   localparam int DEPTH  = 48;
   localparam int AWP    = 6;
   localparam int MEMSZ  = 1 << AWP;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            m0_req, m0_we, m1_req, m1_we;
   logic [31:0]     m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic            m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
   logic [31:0]     m0_rdata, m1_rdata;
   logic            mem_we;
   logic [AWP-1:0]  mem_addr;
   logic [31:0]     mem_wdata, mem_rdata;

   logic [31:0]     benchMem [MEMSZ];
   logic [31:0]     refMem   [MEMSZ];

   int passCount = 0;
   int totalCount = 0;

   dmem_arbiter #(
      .WORD(32), .DMEM_OFFSET(OFFSET), .DMEM_DEPTH(DEPTH), .AW(AWP)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Bench-side data memory: combinational read, synchronous write.
   assign mem_rdata = benchMem[mem_addr];
   always @(posedge clk) begin
      if (mem_we) benchMem[mem_addr] <= mem_wdata;
   end

   task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
      totalCount++;
      if (got !== exp) $display("[TB] FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
      else passCount++;
   endtask

   task automatic applyStimulus(input int m, input logic req, input logic we,
                                input logic [31:0] addr, input logic [31:0] wdata);
      if (m == 0) begin
         m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
      end else begin
         m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
      end
   endtask

   function automatic bit isFault(input logic [31:0] a);
      longint w = longint'(a >> 2);
      return (a[1:0] != 2'b00) || (w < OFFSET) || (w - OFFSET >= DEPTH);
   endfunction

   function automatic int wordIdx(input logic [31:0] a);
      longint w = longint'(a >> 2);
      return int'((w - OFFSET) & longint'(MEMSZ - 1));
   endfunction

   // Transaction-level model: an accepted access owns the following cycle (grant, memory
   // driven) and completes in the cycle after that, when the next acceptance may overlap.
   bit          issuing = 0;
   int          lastWinner = 1;
   int          winner;
   int          curOwner;
   bit          curWe;
   logic [31:0] curAddr, curWdata;
   bit          curFault;
   bit          expGnt[2] = '{0, 0};
   bit          expRvalid[2] = '{0, 0};
   bit          expErr[2] = '{0, 0};
   logic [31:0] expRdata[2] = '{0, 0};
   bit          expMemWe = 0;
   logic [31:0] expMemAddr = 0;
   logic [31:0] expMemWdata = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issuing = 0;
         lastWinner = 1;
         for (int m = 0; m < 2; m++) begin
            expGnt[m] = 0; expRvalid[m] = 0; expErr[m] = 0; expRdata[m] = 0;
         end
         expMemWe = 0; expMemAddr = 0; expMemWdata = 0;
      end else begin
         for (int m = 0; m < 2; m++) begin
            expGnt[m] = 0; expRvalid[m] = 0; expErr[m] = 0;
         end
         expMemWe = 0; expMemAddr = 0; expMemWdata = 0;
         if (issuing) begin
            issuing = 0;
            expRvalid[curOwner] = 1;
            expErr[curOwner] = curFault;
            expRdata[curOwner] = (curWe || curFault) ? 32'h0 : refMem[wordIdx(curAddr)];
            if (curWe && !curFault) refMem[wordIdx(curAddr)] = curWdata;
         end else if (m0_req || m1_req) begin
            if (m0_req && m1_req) winner = 1 - lastWinner;
            else winner = m1_req ? 1 : 0;
            lastWinner = winner;
            curOwner = winner;
            curWe    = (winner == 1) ? m1_we    : m0_we;
            curAddr  = (winner == 1) ? m1_addr  : m0_addr;
            curWdata = (winner == 1) ? m1_wdata : m0_wdata;
            curFault = isFault(curAddr);
            issuing = 1;
            expGnt[winner] = 1;
            expMemWe = curWe && !curFault;
            expMemAddr = 32'(wordIdx(curAddr));
            expMemWdata = curWdata;
         end
      end
   end

   // Every cycle, away from the rising edge, all outputs are compared with the model.
   always @(negedge clk) begin
      checkOutput("m0_gnt", m0_gnt, expGnt[0]);
      checkOutput("m1_gnt", m1_gnt, expGnt[1]);
      checkOutput("m0_rvalid", m0_rvalid, expRvalid[0]);
      checkOutput("m1_rvalid", m1_rvalid, expRvalid[1]);
      checkOutput("m0_err", m0_err, expErr[0]);
      checkOutput("m1_err", m1_err, expErr[1]);
      checkOutput("m0_rdata", m0_rdata, expRdata[0]);
      checkOutput("m1_rdata", m1_rdata, expRdata[1]);
      checkOutput("mem_we", mem_we, expMemWe);
      checkOutput("mem_addr", 32'(mem_addr), expMemAddr);
      checkOutput("mem_wdata", mem_wdata, expMemWdata);
   end

   // Raise a request, wait (bounded) for its grant, then stop in the response cycle.
   task automatic runAccess(input int m, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic gntWe,
                            output logic [31:0] gntAddr, output logic [31:0] gntWdata);
      bit seen = 0;
      #1 applyStimulus(m, 1'b1, we, addr, wdata);
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         seen = (m == 0) ? m0_gnt : m1_gnt;
      end
      checkOutput("access_granted", 32'(seen), 32'd1);
      gntWe = mem_we; gntAddr = 32'(mem_addr); gntWdata = mem_wdata;
      #1 applyStimulus(m, 1'b0, 1'b0, 32'h0, 32'h0);
      @(negedge clk);
   endtask

   function automatic logic [31:0] randAddr();
      int sel = $urandom_range(0, 9);
      if (sel <= 5) return 32'((OFFSET + $urandom_range(0, DEPTH - 1)) * 4);
      if (sel == 6) return 32'((OFFSET + $urandom_range(0, DEPTH - 1)) * 4 + $urandom_range(1, 3));
      if (sel == 7) return 32'($urandom_range(0, OFFSET * 4 - 1));
      if (sel == 8) return 32'((OFFSET + DEPTH + $urandom_range(0, 15)) * 4);
      return $urandom();
   endfunction

   bit curReq[2] = '{0, 0};
   int waitCnt[2] = '{0, 0};

   task automatic randomMaster(input int m, input bit gnt);
      if (curReq[m]) begin
         if (gnt || waitCnt[m] > 20) begin
            checkOutput($sformatf("m%0d_waitBound", m), 32'(waitCnt[m] <= 6), 32'd1);
            curReq[m] = 0;
            applyStimulus(m, 1'b0, 1'b0, 32'h0, 32'h0);
         end else begin
            waitCnt[m]++;
         end
      end
      if (!curReq[m] && $urandom_range(0, 2) != 0) begin
         curReq[m] = 1;
         waitCnt[m] = 0;
         applyStimulus(m, 1'b1, 1'($urandom_range(0, 1)), randAddr(), $urandom());
      end
   endtask

   logic        gWe;
   logic [31:0] gAddr, gWdata;
   logic [1:0]  altExp [8];
   bit          g0, g1;

   initial begin
      for (int i = 0; i < MEMSZ; i++) begin
         benchMem[i] = 32'h1000_0000 + 32'(i * 7);
         refMem[i]   = 32'h1000_0000 + 32'(i * 7);
      end
      rst_n = 1'b0;
      applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      checkOutput("rst_gnt", {m1_gnt, m0_gnt}, 32'd0);
      checkOutput("rst_rvalid", {m1_rvalid, m0_rvalid}, 32'd0);
      checkOutput("rst_memWe", mem_we, 32'd0);
      checkOutput("rst_rdata", m0_rdata | m1_rdata, 32'd0);
      #1 rst_n = 1'b1;

      // Write then read back through the other master.
      runAccess(0, 1'b1, OFFSET * 4 + 8, 32'hDEADBEEF, gWe, gAddr, gWdata);
      checkOutput("wr_memWe", gWe, 32'd1);
      checkOutput("wr_memAddr", gAddr, 32'd2);
      checkOutput("wr_memWdata", gWdata, 32'hDEADBEEF);
      checkOutput("wr_rvalid", m0_rvalid, 32'd1);
      checkOutput("wr_err", m0_err, 32'd0);
      runAccess(1, 1'b0, OFFSET * 4 + 8, 32'h0, gWe, gAddr, gWdata);
      checkOutput("rd_memWe", gWe, 32'd0);
      checkOutput("rd_rvalid", m1_rvalid, 32'd1);
      checkOutput("rd_rdata", m1_rdata, 32'hDEADBEEF);
      checkOutput("rd_m0Idle", {m0_gnt, m0_rvalid, m0_err}, 32'd0);
      runAccess(0, 1'b0, OFFSET * 4 + 8, 32'h0, gWe, gAddr, gWdata);
      checkOutput("rd0_rdata", m0_rdata, 32'hDEADBEEF);

      // Faulting writes: misaligned and one past the end.
      runAccess(0, 1'b1, 32'h6, 32'h12345678, gWe, gAddr, gWdata);
      checkOutput("mis_memWe", gWe, 32'd0);
      checkOutput("mis_err", m0_err, 32'd1);
      checkOutput("mis_rdata", m0_rdata, 32'd0);
      runAccess(0, 1'b0, OFFSET * 4 + 8, 32'h0, gWe, gAddr, gWdata);
      runAccess(0, 1'b1, (OFFSET + DEPTH) * 4, 32'h87654321, gWe, gAddr, gWdata);
      checkOutput("oor_memWe", gWe, 32'd0);
      checkOutput("oor_err", m0_err, 32'd1);
      checkOutput("oor_rdata", m0_rdata, 32'd0);

      // Both masters requesting continuously from reset: grants alternate m0, m1.
      #1 rst_n = 1'b0;
      applyStimulus(0, 1'b1, 1'b0, OFFSET * 4 + 12, 32'h0);
      applyStimulus(1, 1'b1, 1'b0, OFFSET * 4 + 16, 32'h0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      altExp = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checkOutput("alt_gnt", {m1_gnt, m0_gnt}, 32'(altExp[c]));
      end
      #1 applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);

      // Reset in the middle of a write: memory write must vanish at once.
      @(negedge clk);
      #1 applyStimulus(0, 1'b1, 1'b1, OFFSET * 4 + 20, 32'hCAFEF00D);
      @(negedge clk);
      checkOutput("abort_preWe", mem_we, 32'd1);
      #2 rst_n = 1'b0;
      #1 checkOutput("abort_memWe", mem_we, 32'd0);
      checkOutput("abort_gnt", m0_gnt, 32'd0);
      applyStimulus(0, 1'b1, 1'b0, OFFSET * 4 + 20, 32'h0);
      applyStimulus(1, 1'b1, 1'b0, OFFSET * 4 + 24, 32'h0);
      repeat (2) begin
         @(negedge clk);
         checkOutput("abort_noRvalid", m0_rvalid, 32'd0);
      end
      #1 rst_n = 1'b1;
      @(negedge clk);
      checkOutput("abort_tieWinner", {m1_gnt, m0_gnt}, 32'd1);
      #1 applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(negedge clk);
      runAccess(1, 1'b0, OFFSET * 4 + 20, 32'h0, gWe, gAddr, gWdata);
      checkOutput("abort_memUnchanged", m1_rdata, 32'h1000_0000 + 32'(5 * 7));

      // Randomized traffic from both masters.
      for (int cyc = 0; cyc < 800; cyc++) begin
         @(negedge clk);
         g0 = m0_gnt;
         g1 = m1_gnt;
         #1;
         randomMaster(0, g0);
         randomMaster(1, g1);
      end
      applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0);
      applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired at %0t", $time);
      $fatal(1, "[TB] watchdog");
   end

endmodule
